// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and helpers for the two-master memory arbiter.
package mem_arbiter_pkg;

    // Arbiter state encoding.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_BUSY0 = 2'b01,
        ARB_BUSY1 = 2'b10,
        ARB_RESP  = 2'b11
    } arb_state_e;

    // Round-robin pointer holds the last granted port; reset to port 1 so port 0 wins first.
    localparam logic RR_PTR_RESET = 1'b1;

    // One-hot port vector for a port index.
    function automatic logic [1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Busy state that serves the given port.
    function automatic arb_state_e busy_state(input logic idx);
        return idx ? ARB_BUSY1 : ARB_BUSY0;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response handshake of one master port of the arbiter.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ready;

    modport master (output rd, output wr, output addr, output wdata,
                    input rdata, input ready);
    modport slave  (input rd, input wr, input addr, input wdata,
                    output rdata, output ready);
endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational two-way picker; on a tie, round-robin mode grants
// the port not granted last, fixed mode grants port 0.
module arb_pick (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    input  logic       rr_mode_i,
    output logic       gnt_idx_o,
    output logic       gnt_vld_o
);

    // Select the granted port among the eligible requests.
    always_comb begin
        gnt_idx_o = 1'b0;
        gnt_vld_o = 1'b0;
        case (req_i)
            2'b01: begin
                gnt_idx_o = 1'b0;
                gnt_vld_o = 1'b1;
            end
            2'b10: begin
                gnt_idx_o = 1'b1;
                gnt_vld_o = 1'b1;
            end
            2'b11: begin
                gnt_idx_o = rr_mode_i ? ~ptr_i : 1'b0;
                gnt_vld_o = 1'b1;
            end
            default: begin
                gnt_idx_o = 1'b0;
                gnt_vld_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory bus between two masters, one
// transaction at a time. Define MEM_ARBITER_RR_EN for round-robin tie
// breaking; otherwise port 0 has fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  m0_if,
    mem_arbiter_if.slave  m1_if,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          mem_memread_o,
    output logic          mem_memwrite_o,
    input  logic          mem_ready_i,
    output logic          arb_owner_o,
    output logic          arb_busy_o
);

    localparam logic [AW-1:0] ALIGN_MASK = {{(AW-2){1'b1}}, 2'b00};

    arb_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          op_wr_q, op_wr_d;
    logic          owner_q, owner_d;
    logic          busy_q, busy_d;
    logic          rd_stb_q, rd_stb_d, wr_stb_q, wr_stb_d;
    logic          ready0_q, ready0_d, ready1_q, ready1_d;
    logic [1:0]    req_s, mask_s, elig_s;
    logic          gnt_idx_s, gnt_vld_s, can_grant_s, in_busy_d_s, done_s;
    logic          ptr_s, rr_mode_s;

    assign req_s  = {m1_if.rd | m1_if.wr, m0_if.rd | m0_if.wr};
    // The port just served still holds its request during RESP.
    assign mask_s = (state_q == ARB_RESP) ? port_onehot(owner_q) : 2'b00;
    assign elig_s = req_s & ~mask_s;

`ifdef MEM_ARBITER_RR_EN
    logic ptr_q, ptr_d;

    // Pointer remembers the most recent grant.
    always_comb ptr_d = can_grant_s ? gnt_idx_s : ptr_q;

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= RR_PTR_RESET;
        else        ptr_q <= ptr_d;
    end

    assign ptr_s     = ptr_q;
    assign rr_mode_s = 1'b1;
`else
    assign ptr_s     = 1'b0;
    assign rr_mode_s = 1'b0;
`endif

    arb_pick u_pick (
        .req_i     (elig_s),
        .ptr_i     (ptr_s),
        .rr_mode_i (rr_mode_s),
        .gnt_idx_o (gnt_idx_s),
        .gnt_vld_o (gnt_vld_s)
    );

    // Next-state logic: grant from IDLE or directly from RESP, wait on mem_ready in BUSYn.
    always_comb begin
        state_d     = state_q;
        can_grant_s = 1'b0;
        case (state_q)
            ARB_IDLE, ARB_RESP: begin
                if (gnt_vld_s) begin
                    state_d     = busy_state(gnt_idx_s);
                    can_grant_s = 1'b1;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY0, ARB_BUSY1: begin
                if (mem_ready_i) state_d = ARB_RESP;
                else             state_d = state_q;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Datapath next values: latch on grant, capture read data and raise ready on completion.
    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        op_wr_d  = op_wr_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ready0_d = 1'b0;
        ready1_d = 1'b0;
        if (can_grant_s) begin
            addr_d  = (gnt_idx_s ? m1_if.addr : m0_if.addr) & ALIGN_MASK;
            wdata_d = gnt_idx_s ? m1_if.wdata : m0_if.wdata;
            op_wr_d = gnt_idx_s ? m1_if.wr : m0_if.wr;
        end else begin
            op_wr_d = op_wr_q;
        end
        done_s = mem_ready_i && ((state_q == ARB_BUSY0) || (state_q == ARB_BUSY1));
        if (done_s) begin
            if (state_q == ARB_BUSY1) begin
                ready1_d = 1'b1;
                rdata1_d = op_wr_q ? rdata1_q : mem_rdata_i;
            end else begin
                ready0_d = 1'b1;
                rdata0_d = op_wr_q ? rdata0_q : mem_rdata_i;
            end
        end else begin
            ready0_d = 1'b0;
            ready1_d = 1'b0;
        end
        in_busy_d_s = (state_d == ARB_BUSY0) || (state_d == ARB_BUSY1);
        rd_stb_d    = in_busy_d_s & ~op_wr_d;
        wr_stb_d    = in_busy_d_s & op_wr_d;
        busy_d      = (state_d != ARB_IDLE);
        case (state_d)
            ARB_BUSY0: owner_d = 1'b0;
            ARB_BUSY1: owner_d = 1'b1;
            ARB_RESP:  owner_d = owner_q;
            default:   owner_d = 1'b0;
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            addr_q   <= {AW{1'b0}};
            wdata_q  <= {DW{1'b0}};
            op_wr_q  <= 1'b0;
            rdata0_q <= {DW{1'b0}};
            rdata1_q <= {DW{1'b0}};
            ready0_q <= 1'b0;
            ready1_q <= 1'b0;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            owner_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            op_wr_q  <= op_wr_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ready0_q <= ready0_d;
            ready1_q <= ready1_d;
            rd_stb_q <= rd_stb_d;
            wr_stb_q <= wr_stb_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
        end
    end

    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;
    assign mem_memread_o  = rd_stb_q;
    assign mem_memwrite_o = wr_stb_q;
    assign arb_owner_o    = owner_q;
    assign arb_busy_o     = busy_q;
    assign m0_if.rdata    = rdata0_q;
    assign m0_if.ready    = ready0_q;
    assign m1_if.rdata    = rdata1_q;
    assign m1_if.ready    = ready1_q;

endmodule
